// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: frame geometry, sample type, the
// reorder-stage state encoding and a bit-reversal helper.
package fft_pkg;

   localparam int N_POINTS = 8;
   localparam int LOG2N    = $clog2(N_POINTS);
   localparam int DATA_W   = 8;

   typedef logic [DATA_W-1:0] sample_t;
   typedef logic [LOG2N-1:0]  index_t;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   // Reverse the LOG2N index bits (N=8: 1 -> 4, 3 -> 6)
   function automatic index_t bitrev(input index_t idx);
      index_t rev;
      rev = '0;
      for (int i = 0; i < LOG2N; i++) begin
         rev[i] = idx[LOG2N-1-i];
      end
      return rev;
   endfunction

endpackage

// File: rtl/fft_input_reorder_if.sv
// Sample stream in and reordered stream out of the FFT input reorder stage.
// slave: the reorder block; master: the surrounding logic (capture + core).
interface fft_input_reorder_if #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 3
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_index;
   logic              out_last;
   logic              out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      output out_index,
      output out_last,
      input  out_ready
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_index,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/fft_bitrev.sv
// Parameterised combinational index bit reverser.
module fft_bitrev #(
   parameter int W = 3
) (
   input  logic [W-1:0] idx,
   output logic [W-1:0] rev
);

   // Mirror the index bits: bit i of the result is bit W-1-i of the input
   always_comb begin
      rev = '0;
      for (int i = 0; i < W; i++) begin
         rev[i] = idx[W-1-i];
      end
   end

endmodule

// File: rtl/fft_input_reorder.sv
// FFT input reorder stage: collects one frame of samples, writing each
// to its bit-reversed slot, then streams the buffer out in slot order.
// Single buffer: the next frame is accepted only once the drain finishes.
module fft_input_reorder #(
   parameter int N_POINTS = fft_pkg::N_POINTS,
   parameter int DATA_W   = fft_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   fft_input_reorder_if.slave bus
);
   import fft_pkg::*;

   localparam int IDX_W = $clog2(N_POINTS);

   localparam logic [0:0]       S_FILL   = FILL;
   localparam logic [0:0]       S_DRAIN  = DRAIN;
   localparam logic [IDX_W-1:0] CNT_ZERO = IDX_W'(0);
   localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N_POINTS - 1);

   logic [0:0]        state_r;
   logic [IDX_W-1:0]  wr_cnt_r;
   logic [IDX_W-1:0]  rd_cnt_r;
   logic [DATA_W-1:0] mem_r [N_POINTS];

   logic [IDX_W-1:0]  wr_addr_s;
   logic              accept_s;
   logic              xfer_s;

   fft_bitrev #(.W(IDX_W)) u_wr_rev (
      .idx (wr_cnt_r),
      .rev (wr_addr_s)
   );

   // Handshake qualifiers; flush suppresses both the write and the read advance
   always_comb begin
      accept_s = 1'b0;
      xfer_s   = 1'b0;
      if (!flush) begin
         accept_s = (state_r == S_FILL)  && bus.in_valid;
         xfer_s   = (state_r == S_DRAIN) && bus.out_ready;
      end else begin
         accept_s = 1'b0;
         xfer_s   = 1'b0;
      end
   end

   // Frame sequencing: fill counter, drain counter and FILL/DRAIN state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= S_FILL;
         wr_cnt_r <= CNT_ZERO;
         rd_cnt_r <= CNT_ZERO;
      end else if (flush) begin
         state_r  <= S_FILL;
         wr_cnt_r <= CNT_ZERO;
         rd_cnt_r <= CNT_ZERO;
      end else begin
         case (state_r)
            S_FILL: begin
               if (accept_s) begin
                  wr_cnt_r <= wr_cnt_r + CNT_ONE;
                  if (wr_cnt_r == CNT_LAST) begin
                     state_r <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (xfer_s) begin
                  rd_cnt_r <= rd_cnt_r + CNT_ONE;
                  if (rd_cnt_r == CNT_LAST) begin
                     state_r <= S_FILL;
                  end
               end
            end
            default: begin
               state_r  <= S_FILL;
               wr_cnt_r <= CNT_ZERO;
               rd_cnt_r <= CNT_ZERO;
            end
         endcase
      end
   end

   // Sample buffer write into the bit-reversed slot; contents are never cleared
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_r[wr_addr_s] <= bus.in_data;
      end
   end

   // Stream outputs decoded from state and drain counter, zero while filling
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_index = CNT_ZERO;
      bus.out_last  = 1'b0;
      if (state_r == S_DRAIN) begin
         bus.out_valid = 1'b1;
         bus.out_data  = mem_r[rd_cnt_r];
         bus.out_index = rd_cnt_r;
         bus.out_last  = (rd_cnt_r == CNT_LAST);
      end else begin
         bus.in_ready  = 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Self-checking bench for fft_input_reorder (N=8, 8-bit samples).
module tb_fft_input_reorder;

   localparam int NP = 8;
   localparam int DW = 8;
   localparam int IW = 3;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_checks = 0;
   int   n_errors = 0;

   fft_input_reorder_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

   fft_input_reorder #(.N_POINTS(NP), .DATA_W(DW)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [2:0] index;
      logic       last;
   } exp_t;

   typedef struct {
      logic [7:0] din;
      logic [7:0] dout;
      logic [2:0] idx;
      logic       last;
   } vec_t;

   exp_t       sb_q[$];
   logic [7:0] mdl_buf [NP];
   int         wcnt = 0;
   bit         mdl_drain = 1'b0;
   int         n_out = 0;
   int         n_last = 0;
   int         ff_seen = 0;
   bit         bp_mode = 1'b0;
   int         bp_phase = 0;
   bit         prev_hold = 1'b0;
   logic [7:0] prev_data;
   logic [2:0] prev_idx;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int tb_rev(input int v);
      return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
   endfunction

   // Downstream ready: always 1, or the 1,0,0 repeating pattern under backpressure
   always @(posedge clk) begin
      #1;
      if (bp_mode) begin
         bus.out_ready = (bp_phase == 0);
         bp_phase = (bp_phase + 1) % 3;
      end else begin
         bus.out_ready = 1'b1;
      end
   end

   // Monitor and scoreboard: model frame assembly, compare every transfer
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         wcnt = 0;
         mdl_drain = 1'b0;
         prev_hold = 1'b0;
      end else begin
         chk("in_ready", int'(bus.in_ready), int'(!mdl_drain));
         chk("out_valid", int'(bus.out_valid), int'(mdl_drain));
         if (prev_hold) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_data", int'(bus.out_data), int'(prev_data));
            chk("hold_index", int'(bus.out_index), int'(prev_idx));
         end
         prev_hold = bus.out_valid && !bus.out_ready && !flush;
         prev_data = bus.out_data;
         prev_idx  = bus.out_index;
         if (!flush && bus.in_valid && bus.in_ready) begin
            mdl_buf[tb_rev(wcnt)] = bus.in_data;
            wcnt++;
            if (wcnt == NP) begin
               for (int k = 0; k < NP; k++) begin
                  exp_t e;
                  e.data  = mdl_buf[k];
                  e.index = 3'(k);
                  e.last  = (k == NP - 1);
                  sb_q.push_back(e);
               end
               wcnt = 0;
               mdl_drain = 1'b1;
            end
         end
         if (!flush && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (bus.out_data == 8'hFF) ff_seen++;
            if (bus.out_last) n_last++;
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_unexpected actual=%0h expected=none", bus.out_data);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("sb_data", int'(bus.out_data), int'(e.data));
               chk("sb_index", int'(bus.out_index), int'(e.index));
               chk("sb_last", int'(bus.out_last), int'(e.last));
               if (e.last) mdl_drain = 1'b0;
            end
         end
         if (flush) begin
            sb_q.delete();
            wcnt = 0;
            mdl_drain = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] d);
      int t;
      t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      while (!bus.in_ready && t < 100) begin
         t++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout actual=in_ready_low expected=in_ready_high");
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] base, input int gap);
      for (int i = 0; i < NP; i++) begin
         send(base + 8'(i));
         if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || !bus.in_ready) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout actual=%0d_pending expected=0", sb_q.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       tbl [NP];
      logic [7:0] exp_order [NP];
      int         start;
      int         lsnap;
      int         t;

      exp_order = '{8'h10, 8'h14, 8'h12, 8'h16, 8'h11, 8'h15, 8'h13, 8'h17};
      for (int i = 0; i < NP; i++) begin
         tbl[i].din  = 8'h10 + 8'(i);
         tbl[i].dout = exp_order[i];
         tbl[i].idx  = 3'(i);
         tbl[i].last = (i == NP - 1);
      end

      rst = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      #2;
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_last", int'(bus.out_last), 0);
      chk("rst_out_index", int'(bus.out_index), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // basic frame, table-driven
      for (int i = 0; i < NP; i++) send(tbl[i].din);
      chk("first_out_latency", int'(bus.out_valid), 1);
      for (int i = 0; i < NP; i++) begin
         @(negedge clk);
         chk("tbl_data", int'(bus.out_data), int'(tbl[i].dout));
         chk("tbl_index", int'(bus.out_index), int'(tbl[i].idx));
         chk("tbl_last", int'(bus.out_last), int'(tbl[i].last));
         chk("tbl_in_ready", int'(bus.in_ready), 0);
      end
      wait_idle();

      // backpressure
      bp_mode = 1'b1;
      send_frame(8'h10, 0);
      wait_idle();
      bp_mode = 1'b0;

      // input offered during drain must be ignored
      send_frame(8'h50, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      t = 0;
      while (!bus.in_ready && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      bus.in_valid = 1'b0;
      chk("drain_end_in_ready", int'(bus.in_ready), 1);
      send_frame(8'h60, 0);
      wait_idle();
      chk("ff_absent", ff_seen, 0);

      // flush mid-fill with a sample presented on the flush cycle
      send(8'h01);
      send(8'h02);
      send(8'h03);
      flush = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_out_valid", int'(bus.out_valid), 0);
      chk("flush_in_ready", int'(bus.in_ready), 1);
      send_frame(8'h20, 0);
      wait_idle();

      // asynchronous reset after three outputs of a drain
      start = n_out;
      send_frame(8'h70, 0);
      t = 0;
      while (n_out < start + 3 && t < 100) begin
         @(posedge clk);
         t++;
      end
      chk("arst_outputs_seen", n_out - start, 3);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", int'(bus.out_valid), 0);
      chk("arst_in_ready", int'(bus.in_ready), 1);
      chk("arst_out_index", int'(bus.out_index), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_frame(8'h80, 0);
      chk("arst_restart_index", int'(bus.out_index), 0);
      wait_idle();

      // two back-to-back frames with sparse input
      lsnap = n_last;
      send_frame(8'h30, 2);
      send_frame(8'h40, 2);
      wait_idle();
      chk("last_per_frame", n_last - lsnap, 2);

      chk("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fft_input_reorder.md
Name: fft_input_reorder

Overview:
- Upstream stage of the FFT datapath: accepts a stream of real input samples, stores one frame and releases it in bit-reversed order, the input ordering a radix-2 decimation-in-time core needs.
- Sits between the pin-level sample capture logic (ui_in) and the FFT butterfly core.
- Ping-pong-free single buffer: fill a frame, drain it, then accept the next frame.

Parameters:
- N_POINTS, 8, frame length in samples; power of two, 4..16.
- DATA_W, 8, sample width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous abort; empties buffer and returns to FILL.
- in_valid  input  1  upstream sample valid.
- in_data  input  DATA_W  upstream sample.
- in_ready  output  1  block can accept a sample.
- out_valid  output  1  reordered sample available to FFT core.
- out_data  output  DATA_W  reordered sample.
- out_index  output  log2(N_POINTS)  natural-order slot number of out_data (0..N-1).
- out_last  output  1  high with the final sample of a frame.
- out_ready  input  1  FFT core accepts sample.

Behaviour:
- One clock (clk); reset rst is asynchronous, active-high. Reset forces: state=FILL, wr_cnt=0, rd_cnt=0, in_ready=1, out_valid=0, out_last=0, out_index=0, out_data=0. Buffer contents are not reset.
- Storage: N_POINTS x DATA_W register array mem.
- States: FILL, DRAIN.
- FILL: in_ready=1, out_valid=0. On in_valid&&in_ready: mem[bitrev(wr_cnt)] <= in_data; wr_cnt++. When the accepted sample has wr_cnt==N_POINTS-1: wr_cnt wraps to 0, next state DRAIN.
- DRAIN: in_ready=0 (in_valid ignored, no data lost or stored). out_valid=1, out_data=mem[rd_cnt], out_index=rd_cnt, out_last=(rd_cnt==N_POINTS-1); all combinational from rd_cnt/mem. On out_valid&&out_ready: rd_cnt++. When transferring with out_last: rd_cnt wraps to 0, next state FILL.
- Latency: last input accepted at edge t -> out_valid high after edge t (first cycle after). Last output transferred at edge t -> in_ready high after edge t.
- Output stable while out_valid&&!out_ready (AXI-style hold); out_valid never drops without a transfer, except on flush/rst.
- bitrev: reverse the log2(N_POINTS) LSBs of the index; e.g. N=8: 1->4, 3->6.
- flush (sync, priority over all handshakes): next state FILL, wr_cnt=0, rd_cnt=0; a sample presented the same cycle is not accepted (in_ready is still shown but the write is suppressed); out_valid=0 next cycle.
- rst mid-operation: immediate return to reset values; partial frame discarded.
- out_ready while in FILL: ignored.

Decomposition:
- Shared package fft_pkg: N_POINTS, LOG2N, DATA_W constants, sample_t typedef, state enum (FILL, DRAIN), bitrev function. Same package reused by the FFT core.
- One natural sub-module: fft_bitrev (parameterised combinational index reverser); also used by the core's twiddle addressing. Everything else inline.

Test Plan:
- Basic frame: after reset, write 0x10..0x17 with in_valid held, out_ready=1 -> out_data order 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17; out_index 0..7; out_last only on 0x17; in_ready=0 during those 8 cycles.
- Backpressure: same frame, out_ready toggled 1,0,0,1... -> out_data/out_index hold while out_ready=0; same 8-value order; no duplicates or drops.
- Input during DRAIN: drive in_valid=1, in_data=0xFF throughout DRAIN -> 0xFF never appears in the current frame or in the next frame unless accepted after in_ready returns to 1.
- Flush mid-fill: write 0x01,0x02,0x03, pulse flush with in_valid=1/0xAA, then write 0x20..0x27 -> outputs 0x20,0x24,0x22,0x26,0x21,0x25,0x23,0x27; 0xAA absent.
- Async reset mid-drain: assert rst between clock edges after 3 outputs -> out_valid=0, in_ready=1 immediately (before next edge); next full frame drains correctly from index 0.
- Back-to-back frames with sparse in_valid (every 3rd cycle): two frames 0x30..0x37 then 0x40..0x47 -> each drained in correct bit-reversed order, out_last exactly once per frame.
